router_egress_arbiter: RTL and testbench
========================================

Name: router_egress_arbiter

Overview:
Egress scheduler for the 1x3 router output FIFOs. It shares a single egress byte bus between the three output FIFOs using packet-granular round-robin arbitration. Once a FIFO wins, the grant is held until that packet's last byte has been transferred. It also detects a mid-packet drain stall on the granted FIFO and aborts the packet, pulsing that port's soft reset.

Parameters:
DATA_W, 8, byte width of FIFO data and egress bus
STALL_LIMIT, 30, consecutive empty cycles on the granted FIFO mid-packet before abort (>=2)

Ports:
clock  in  1  system clock
resetn  in  1  synchronous active-low reset
fifo_empty_0/1/2  in  1 each  FIFO empty flag per output port
fifo_dout_0/1/2  in  DATA_W each  show-ahead FIFO head data (valid whenever not empty)
egress_ready  in  1  downstream accepts byte this cycle
read_enb_0/1/2  out  1 each  pop strobe to the FIFO
egress_data  out  DATA_W  byte from the granted FIFO
egress_valid  out  1  egress_data valid
egress_sop  out  1  header byte (first byte of packet)
egress_eop  out  1  parity byte (last byte of packet)
egress_abort  out  1  one-cycle pulse: current packet dropped
grant  out  3  one-hot granted port, 0 when idle
soft_reset_0/1/2  out  1 each  one-cycle flush pulse to the stalled port's FIFO
busy  out  1  state != IDLE

Behaviour:
- Interface: reset resetn, synchronous, active-low; clock clock. All state is updated on posedge clock.
- Packet format (fixed in this codebase): header byte = {len[5:0], addr[1:0]}, then len payload bytes, then 1 parity byte. Total bytes = len+2.
- Reset values: state=IDLE, rr_ptr=2 (so port 0 has first priority), grant=0, remaining=0, stall_cnt=0, first=0. All outputs are 0.
- States: IDLE, XFER, ABORT.
- IDLE:
  - If any fifo_empty_i==0, pick the winner as the first non-empty port in order (rr_ptr+1, rr_ptr+2, rr_ptr+3) mod 3.
  - Register grant=onehot(winner), rr_ptr<=winner, first<=1, stall_cnt<=0, then go to XFER.
  - Otherwise stay in IDLE.
  - Arbitration costs one bubble cycle per packet. No egress outputs are asserted in IDLE.
- XFER (g = granted port):
  - egress_valid = !fifo_empty_g; egress_data = fifo_dout_g (combinational mux, 0 when not valid).
  - xfer = egress_valid & egress_ready; read_enb_g = xfer. Other read_enb are held at 0.
  - egress_sop = egress_valid & first.
  - egress_eop = egress_valid & !first & (remaining==1).
  - On a header xfer: remaining <= len+1 (7-bit), first<=0.
  - On a non-header xfer: remaining <= remaining-1. If it was eop, go to IDLE and grant<=0.
  - stall_cnt: increments on each cycle fifo_empty_g==1; clears on any cycle the FIFO is non-empty.
  - egress_ready==0 with data present does NOT count as stall. Backpressure may last indefinitely.
  - If fifo_empty_g && stall_cnt==STALL_LIMIT-1, go to ABORT. The abort fires on the STALL_LIMIT-th consecutive empty cycle.
  - A stall before the header (first==1) counts identically.
- ABORT (one cycle):
  - soft_reset_g=1, egress_abort=1, egress_valid=0, all read_enb=0.
  - Next state IDLE with grant=0. rr_ptr keeps the aborted port, so it has lowest priority next.
- Invariants:
  - At most one read_enb is high at a time.
  - read_enb is never high while the corresponding FIFO is empty.
  - sop and eop are never high in the same cycle (minimum packet is 2 bytes).
  - egress_data, sop and eop are held stable while valid && !ready.
- len=0: after the header remaining=1, so the next byte (parity) is eop.
- resetn low mid-packet: everything returns to reset values on that edge. No abort or soft_reset pulse is issued.
- FIFOs becoming non-empty while another port is granted: they wait. No preemption.

Test Plan:
- Port1 holds 0x0D,0xA1,0xA2,0xA3,0x5F (len 3), egress_ready=1 -> grant=3'b010 one cycle after the request. Five consecutive beats: sop on 0x0D, eop on 0x5F. read_enb_1 pulses 5 times. IDLE on the cycle after eop.
- All three ports loaded with one len=1 packet each after reset -> grant order 001, 010, 100 with one idle bubble between packets. Reload port0 -> granted next.
- Port0 len=4 packet, egress_ready low for 40 cycles after the 2nd byte -> egress_data/valid held. No abort, no soft_reset. Remaining 4 bytes complete with eop.
- Port2 len=5, FIFO goes empty after 2 bytes for 30 cycles with port0 pending -> on the 30th empty cycle ABORT is entered; the following cycle shows soft_reset_2=1 and egress_abort=1 for exactly one cycle. Then IDLE, then port0 granted.
- Port0 header 0x00, parity 0x00 -> sop cycle then eop cycle, 2 reads, busy deasserts afterwards.
- resetn low during payload of a port1 packet -> next edge: grant=0, all outputs 0. After release, port0 and port1 both pending -> port0 granted first.

Source files
------------

// File: rtl/router_egress_if.sv
// Egress-side bundle of the router arbiter: three show-ahead output FIFOs feeding one byte bus.
// The arbiter takes the master modport; the FIFO/downstream environment takes the slave modport.
interface router_egress_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic [DATA_W-1:0] fifo_dout_0, fifo_dout_1, fifo_dout_2;
  logic              read_enb_0, read_enb_1, read_enb_2;
  logic              soft_reset_0, soft_reset_1, soft_reset_2;
  logic              egress_ready;
  logic [DATA_W-1:0] egress_data;
  logic              egress_valid;
  logic              egress_sop;
  logic              egress_eop;
  logic              egress_abort;
  logic [2:0]        grant;
  logic              busy;

  modport master (
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  fifo_dout_0, fifo_dout_1, fifo_dout_2,
    input  egress_ready,
    output read_enb_0, read_enb_1, read_enb_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output egress_data, egress_valid, egress_sop, egress_eop, egress_abort,
    output grant, busy
  );

  modport slave (
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output fifo_dout_0, fifo_dout_1, fifo_dout_2,
    output egress_ready,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  egress_data, egress_valid, egress_sop, egress_eop, egress_abort,
    input  grant, busy
  );
endinterface

// File: rtl/router_egress_arbiter.sv
// Egress scheduler: packet-granular round-robin over three show-ahead router FIFOs, with
// a mid-packet drain-stall abort that flushes the stalled port through its soft reset.
module router_egress_arbiter #(
  parameter int DATA_W      = 8,
  parameter int STALL_LIMIT = 30
) (
  input  logic            clock,
  input  logic            resetn,
  router_egress_if.master bus
);
  localparam int CNT_W = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       rr_q, rr_d;
  logic [2:0]       grant_q, grant_d;
  logic [6:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             first_q, first_d;

  logic [2:0]        empty;
  logic [DATA_W-1:0] dout [3];
  logic              g_empty;
  logic [DATA_W-1:0] g_dout;
  logic [5:0]        hdr_len;
  logic [1:0]        winner;
  logic              xfer;

  logic              eg_valid, eg_sop, eg_eop, eg_abort;
  logic [DATA_W-1:0] eg_data;
  logic [2:0]        rd_enb, srst;

  function automatic logic [1:0] rr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Scan order starts just after the last winner, so the last winner is checked last.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    logic [1:0] c1, c2;
    c1 = rr_inc(last);
    c2 = rr_inc(c1);
    if (req[c1])      return c1;
    else if (req[c2]) return c2;
    return last;
  endfunction

  assign empty   = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign dout[0] = bus.fifo_dout_0;
  assign dout[1] = bus.fifo_dout_1;
  assign dout[2] = bus.fifo_dout_2;

  // rr_q always names the granted port while a grant is held.
  assign g_empty = empty[rr_q];
  assign g_dout  = dout[rr_q];
  assign hdr_len = g_dout[7:2];
  assign winner  = rr_pick(rr_q, ~empty);
  assign xfer    = (state_q == XFER) && !g_empty && bus.egress_ready;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      rr_q    <= 2'd2;
      grant_q <= '0;
      rem_q   <= '0;
      stall_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      rem_q   <= rem_d;
      stall_q <= stall_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    rem_d   = rem_q;
    stall_d = stall_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (empty != 3'b111) begin
          state_d = XFER;
          grant_d = 3'b001 << winner;
          rr_d    = winner;
          first_d = 1'b1;
          stall_d = '0;
        end
      end
      XFER: begin
        if (xfer) begin
          if (first_q) begin
            rem_d   = {1'b0, hdr_len} + 7'd1;
            first_d = 1'b0;
          end else begin
            rem_d = rem_q - 7'd1;
            if (rem_q == 7'd1) begin
              state_d = IDLE;
              grant_d = '0;
            end
          end
        end
        // Only an empty FIFO counts as stall; downstream backpressure never does.
        if (g_empty) begin
          if (stall_q == CNT_W'(STALL_LIMIT - 1)) state_d = ABORT;
          else                                    stall_d = stall_q + 1'b1;
        end else begin
          stall_d = '0;
        end
      end
      ABORT: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    eg_valid = 1'b0;
    eg_data  = '0;
    eg_sop   = 1'b0;
    eg_eop   = 1'b0;
    eg_abort = 1'b0;
    rd_enb   = '0;
    srst     = '0;
    case (state_q)
      XFER: begin
        eg_valid = !g_empty;
        eg_data  = g_empty ? '0 : g_dout;
        eg_sop   = !g_empty && first_q;
        eg_eop   = !g_empty && !first_q && (rem_q == 7'd1);
        rd_enb   = xfer ? grant_q : 3'b000;
      end
      ABORT: begin
        eg_abort = 1'b1;
        srst     = grant_q;
      end
      default: ;
    endcase
  end

  assign bus.egress_valid = eg_valid;
  assign bus.egress_data  = eg_data;
  assign bus.egress_sop   = eg_sop;
  assign bus.egress_eop   = eg_eop;
  assign bus.egress_abort = eg_abort;
  assign bus.read_enb_0   = rd_enb[0];
  assign bus.read_enb_1   = rd_enb[1];
  assign bus.read_enb_2   = rd_enb[2];
  assign bus.soft_reset_0 = srst[0];
  assign bus.soft_reset_1 = srst[1];
  assign bus.soft_reset_2 = srst[2];
  assign bus.grant        = grant_q;
  assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_router_egress_arbiter.sv
// Bench for router_egress_arbiter: queue-backed FIFOs feed the DUT and a packet-level
// reference model predicts grant, beat framing, stall abort and flush every cycle.
module tb_router_egress_arbiter;
  localparam int DATA_W      = 8;
  localparam int STALL_LIMIT = 30;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  router_egress_if #(.DATA_W(DATA_W)) bus ();

  router_egress_arbiter #(.DATA_W(DATA_W), .STALL_LIMIT(STALL_LIMIT)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Environment FIFOs (show-ahead) and downstream ready mode: 0 always, 1 random, 2 held low.
  logic [7:0] fq [3][$];
  int         rmode = 0;

  // Reference model: which port owns the bus, how far into its packet we are.
  int m_port  = -1;
  int m_last  = 2;
  int m_beat  = 0;
  int m_total = 0;
  int m_run   = 0;
  bit m_abort = 1'b0;

  int         n_rd [3];
  int         n_srst [3];
  int         n_abort;
  logic [2:0] glog [$];
  logic [2:0] prev_grant = 3'b000;

  task automatic clear_tally();
    for (int k = 0; k < 3; k++) begin
      n_rd[k]   = 0;
      n_srst[k] = 0;
    end
    n_abort = 0;
    glog.delete();
  endtask

  task automatic drive_fifo();
    bus.fifo_empty_0 = (fq[0].size() == 0);
    bus.fifo_empty_1 = (fq[1].size() == 0);
    bus.fifo_empty_2 = (fq[2].size() == 0);
    bus.fifo_dout_0  = (fq[0].size() != 0) ? fq[0][0] : 8'hEE;
    bus.fifo_dout_1  = (fq[1].size() != 0) ? fq[1][0] : 8'hEE;
    bus.fifo_dout_2  = (fq[2].size() != 0) ? fq[2][0] : 8'hEE;
  endtask

  task automatic push_byte(input int p, input logic [7:0] b);
    fq[p].push_back(b);
  endtask

  task automatic load_pkt(input int p, input int len);
    logic [7:0] b, par;
    b   = {6'(len), 2'(p)};
    par = b;
    push_byte(p, b);
    for (int i = 0; i < len; i++) begin
      b   = 8'($urandom_range(255));
      par = par ^ b;
      push_byte(p, b);
    end
    push_byte(p, par);
  endtask

  task automatic cycle();
    logic [2:0] ne, rd, sr, e_grant, e_rd, e_sr;
    logic [7:0] e_data, head;
    logic       e_busy, e_valid, e_sop, e_eop, e_abort, rdy, rst_s;
    int         w;
    case (rmode)
      0:       bus.egress_ready = 1'b1;
      1:       bus.egress_ready = ($urandom_range(3) != 0);
      default: bus.egress_ready = 1'b0;
    endcase
    drive_fifo();
    @(negedge clock);
    rst_s = !resetn;
    rdy   = bus.egress_ready;
    ne    = {fq[2].size() != 0, fq[1].size() != 0, fq[0].size() != 0};
    rd    = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
    sr    = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};

    head    = 8'h00;
    e_grant = 3'b000; e_rd = 3'b000; e_sr = 3'b000; e_data = 8'h00;
    e_busy  = 1'b0; e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_abort = 1'b0;
    if (m_port >= 0) begin
      e_grant = 3'(1 << m_port);
      e_busy  = 1'b1;
      if (m_abort) begin
        e_sr    = e_grant;
        e_abort = 1'b1;
      end else if (ne[m_port]) begin
        head    = fq[m_port][0];
        e_valid = 1'b1;
        e_data  = head;
        e_sop   = (m_beat == 0);
        e_eop   = (m_beat != 0) && (m_beat == m_total - 1);
        if (rdy) e_rd = e_grant;
      end
    end
    chk("grant", bus.grant, e_grant);
    chk("busy", bus.busy, e_busy);
    chk("valid", bus.egress_valid, e_valid);
    chk("data", bus.egress_data, e_data);
    chk("sop", bus.egress_sop, e_sop);
    chk("eop", bus.egress_eop, e_eop);
    chk("read_enb", rd, e_rd);
    chk("soft_reset", sr, e_sr);
    chk("abort", bus.egress_abort, e_abort);

    for (int k = 0; k < 3; k++) begin
      n_rd[k]   += int'(rd[k]);
      n_srst[k] += int'(sr[k]);
    end
    n_abort += int'(bus.egress_abort);
    if (bus.grant != 3'b000 && prev_grant == 3'b000) glog.push_back(bus.grant);
    prev_grant = bus.grant;

    if (rst_s) begin
      m_port = -1; m_last = 2; m_abort = 1'b0; m_beat = 0; m_run = 0;
    end else if (m_abort) begin
      m_abort = 1'b0;
      m_port  = -1;
    end else if (m_port < 0) begin
      w = -1;
      for (int k = 1; k <= 3; k++)
        if (w < 0 && ne[(m_last + k) % 3]) w = (m_last + k) % 3;
      if (w >= 0) begin
        m_port = w; m_last = w; m_beat = 0; m_run = 0;
      end
    end else if (!ne[m_port]) begin
      m_run++;
      if (m_run == STALL_LIMIT) m_abort = 1'b1;
    end else begin
      m_run = 0;
      if (rdy) begin
        if (m_beat == 0) begin
          m_total = int'(head[7:2]) + 2;
          m_beat  = 1;
        end else if (m_beat == m_total - 1) begin
          m_port = -1;
        end else begin
          m_beat++;
        end
      end
    end

    @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rst_s) fq[k].delete();
      else begin
        if (rd[k] && fq[k].size() != 0) void'(fq[k].pop_front());
        if (sr[k]) fq[k].delete();
      end
    end
  endtask

  task automatic run_until_idle(input string tag, input int max);
    int n;
    n = 0;
    while (n < max && !(m_port < 0 && fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0)) begin
      cycle();
      n++;
    end
    chk({tag, "_drained"}, n < max, 1'b1);
    cycle();
    cycle();
  endtask

  task automatic wait_beat(input string tag, input int p, input int beat, input int max);
    int n;
    n = 0;
    while (n < max && !(m_port == p && m_beat == beat)) begin
      cycle();
      n++;
    end
    chk({tag, "_reached"}, n < max, 1'b1);
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    clear_tally();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_tally();
    bus.egress_ready = 1'b0;
    drive_fifo();
    repeat (2) @(posedge clock);
    #1;
    cycle();
    resetn = 1'b1;
    clear_tally();

    // Single len=3 packet on port 1.
    push_byte(1, 8'h0D); push_byte(1, 8'hA1); push_byte(1, 8'hA2);
    push_byte(1, 8'hA3); push_byte(1, 8'h5F);
    run_until_idle("t1", 20);
    chk("t1_reads_p1", n_rd[1], 5);
    chk("t1_grants", glog.size(), 1);
    chk("t1_grant0", glog[0], 3'b010);

    // Round-robin across three pending ports, then port 0 again.
    reset_dut();
    for (int p = 0; p < 3; p++) load_pkt(p, 1);
    run_until_idle("t2", 40);
    chk("t2_grants", glog.size(), 3);
    chk("t2_g0", glog[0], 3'b001);
    chk("t2_g1", glog[1], 3'b010);
    chk("t2_g2", glog[2], 3'b100);
    for (int p = 0; p < 3; p++) load_pkt(p, 1);
    run_until_idle("t2b", 40);
    chk("t2_g3", glog[3], 3'b001);

    // Long backpressure mid-packet must not be mistaken for a stall.
    clear_tally();
    load_pkt(0, 4);
    wait_beat("t3", 0, 2, 10);
    rmode = 2;
    repeat (40) cycle();
    rmode = 0;
    run_until_idle("t3", 20);
    chk("t3_abort", n_abort, 0);
    chk("t3_srst0", n_srst[0], 0);
    chk("t3_reads_p0", n_rd[0], 6);

    // Port 2 drains dry mid-packet while port 0 waits.
    reset_dut();
    push_byte(2, 8'h16); push_byte(2, 8'h21);
    cycle();
    load_pkt(0, 2);
    run_until_idle("t4", 120);
    chk("t4_abort", n_abort, 1);
    chk("t4_srst2", n_srst[2], 1);
    chk("t4_srst0", n_srst[0], 0);
    chk("t4_reads_p2", n_rd[2], 2);
    chk("t4_grants", glog.size(), 2);
    chk("t4_g0", glog[0], 3'b100);
    chk("t4_g1", glog[1], 3'b001);

    // Minimum packet: header then parity.
    clear_tally();
    push_byte(0, 8'h00); push_byte(0, 8'h00);
    run_until_idle("t5", 10);
    chk("t5_reads_p0", n_rd[0], 2);
    chk("t5_grant0", glog[0], 3'b001);

    // Reset in the middle of a port 1 payload.
    reset_dut();
    load_pkt(1, 4);
    wait_beat("t6", 1, 2, 10);
    resetn = 1'b0;
    cycle();
    cycle();
    resetn = 1'b1;
    clear_tally();
    load_pkt(1, 2);
    load_pkt(0, 2);
    run_until_idle("t6", 30);
    chk("t6_abort", n_abort, 0);
    chk("t6_grant0", glog[0], 3'b001);
    chk("t6_grant1", glog[1], 3'b010);

    // Random traffic with random backpressure.
    clear_tally();
    rmode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) begin
        int p;
        p = $urandom_range(2);
        if (fq[p].size() < 30) load_pkt(p, $urandom_range(6));
      end
      cycle();
    end
    run_until_idle("t7", 2000);
    chk("t7_abort", n_abort, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
